pc_next_unit: RTL and testbench



---
 rtl/pc_next_unit.sv | 134 +++++++++++++
 tb/tb_pc_next_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Fetch PC register. Priority is flush, EX branch, RAS pop, then sequential advance.
// A redirect appears on pc_out one cycle later. Stall holds only sequential flow and the RAS.
module pc_next_unit #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        flush_valid,
    input  logic [XLEN-1:0]             flush_target,
    input  logic                        br_valid,
    input  logic [1:0]                  br_sel,
    input  logic [XLEN-1:0]             br_base_pc,
    input  logic [XLEN-1:0]             rs1_value,
    input  logic [XLEN-1:0]             imm_offset,
    input  logic                        ras_push,
    input  logic                        ras_pop,
    output logic [XLEN-1:0]             pc_out,
    output logic                        pc_valid,
    output logic                        redirect_taken,
    output logic                        misalign_err,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_ERR} state_t;

    state_t           state, state_nxt;
    logic [XLEN-1:0]  pc_nxt, pc_seq, br_target, ras_top;
    logic             valid_nxt, redir_nxt, mis_nxt;
    logic             br_legal, do_push, do_pop, ras_clear;
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;      // next free slot; wraps onto the oldest entry when full
    logic [PW-1:0]    top_idx;

    assign pc_seq    = pc_out + XLEN'(4);
    assign br_legal  = br_valid && (br_sel == 2'b01 || br_sel == 2'b10);
    assign br_target = (br_sel == 2'b01) ? (br_base_pc + imm_offset)
                                         : ((rs1_value + imm_offset) & ~XLEN'(1));
    assign top_idx   = ras_ptr - PW'(1);
    assign ras_top   = ras_mem[top_idx];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_out;
        valid_nxt = pc_valid;
        redir_nxt = 1'b0;
        mis_nxt   = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        ras_clear = 1'b0;
        case (state)
            S_BOOT: begin
                state_nxt = S_RUN;
                valid_nxt = 1'b1;
            end
            S_RUN: begin
                if (flush_valid) begin
                    pc_nxt    = flush_target;
                    redir_nxt = 1'b1;
                    ras_clear = 1'b1;
                end else if (br_legal) begin
                    // Misaligned targets freeze fetch until a trusted flush arrives
                    if (br_target[1]) begin
                        mis_nxt   = 1'b1;
                        valid_nxt = 1'b0;
                        state_nxt = S_ERR;
                    end else begin
                        pc_nxt    = br_target;
                        redir_nxt = 1'b1;
                    end
                end else if (!stall) begin
                    do_push = ras_push;
                    if (ras_pop && ras_count != '0) begin
                        do_pop    = 1'b1;
                        pc_nxt    = ras_top;
                        redir_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc_seq;
                    end
                end
            end
            S_ERR: begin
                if (flush_valid) begin
                    pc_nxt    = flush_target;
                    valid_nxt = 1'b1;
                    redir_nxt = 1'b1;
                    ras_clear = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_BOOT;
            pc_out         <= RESET_VECTOR;
            pc_valid       <= 1'b0;
            redirect_taken <= 1'b0;
            misalign_err   <= 1'b0;
            ras_ptr        <= '0;
            ras_count      <= '0;
        end else begin
            state          <= state_nxt;
            pc_out         <= pc_nxt;
            pc_valid       <= valid_nxt;
            redirect_taken <= redir_nxt;
            misalign_err   <= mis_nxt;
            if (ras_clear) begin
                ras_ptr   <= '0;
                ras_count <= '0;
            end else if (do_push && !do_pop) begin
                ras_ptr <= ras_ptr + PW'(1);
                if (ras_count != CW'(RAS_DEPTH))
                    ras_count <= ras_count + CW'(1);
            end else if (do_pop && !do_push) begin
                ras_ptr   <= top_idx;
                ras_count <= ras_count - CW'(1);
            end
        end
    end

    // Push with pop in the same cycle overwrites the top in place
    always_ff @(posedge clk) begin
        if (do_push)
            ras_mem[do_pop ? top_idx : ras_ptr] <= pc_seq;
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: queue-based reference model checked every cycle, plus hand-computed pins.
module tb_pc_next_unit;
    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0100;
    localparam int          DEP  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush_valid, br_valid, ras_push, ras_pop;
    logic [1:0]  br_sel;
    logic [31:0] flush_target, br_base_pc, rs1_value, imm_offset;
    logic [31:0] pc_out;
    logic        pc_valid, redirect_taken, misalign_err;
    logic [2:0]  ras_count;

    pc_next_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .flush_valid(flush_valid), .flush_target(flush_target),
        .br_valid(br_valid), .br_sel(br_sel), .br_base_pc(br_base_pc),
        .rs1_value(rs1_value), .imm_offset(imm_offset),
        .ras_push(ras_push), .ras_pop(ras_pop),
        .pc_out(pc_out), .pc_valid(pc_valid), .redirect_taken(redirect_taken),
        .misalign_err(misalign_err), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = booting, 1 = running, 2 = halted on misaligned target
    int          m_mode;
    logic [31:0] m_pc, m_tgt, m_link;
    logic        m_valid, m_redir, m_mis;
    logic [31:0] m_ras[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = RV; m_valid = 0; m_redir = 0; m_mis = 0;
            m_ras.delete();
        end else begin
            m_redir = 0;
            m_mis   = 0;
            if (m_mode == 0) begin
                m_mode  = 1;
                m_valid = 1;
            end else if (m_mode == 2) begin
                if (flush_valid) begin
                    m_pc = flush_target; m_valid = 1; m_redir = 1; m_mode = 1;
                    m_ras.delete();
                end
            end else if (flush_valid) begin
                m_pc = flush_target; m_redir = 1;
                m_ras.delete();
            end else if (br_valid && (br_sel == 2'd1 || br_sel == 2'd2)) begin
                if (br_sel == 2'd1) m_tgt = br_base_pc + imm_offset;
                else                m_tgt = (rs1_value + imm_offset) & 32'hFFFF_FFFE;
                if (m_tgt[1]) begin
                    m_mis = 1; m_valid = 0; m_mode = 2;
                end else begin
                    m_pc = m_tgt; m_redir = 1;
                end
            end else if (!stall) begin
                m_link = m_pc + 32'd4;
                if (ras_pop && m_ras.size() > 0) begin
                    m_pc    = m_ras.pop_back();
                    m_redir = 1;
                end else begin
                    m_pc = m_link;
                end
                if (ras_push) begin
                    m_ras.push_back(m_link);
                    if (m_ras.size() > DEP) void'(m_ras.pop_front());
                end
            end
        end
    end

    // Hand-computed expectations handed to the compare process
    int          checks = 0, errors = 0;
    int          lit_seq = 0, lit_done = 0;
    string       lit_name;
    logic [31:0] lit_pc;
    logic        lit_valid, lit_redir, lit_mis;
    logic [2:0]  lit_cnt;
    event        probe;

    always @(negedge clk or probe) begin
        checks++;
        if ({pc_out, pc_valid, redirect_taken, misalign_err, ras_count} !==
            {m_pc, m_valid, m_redir, m_mis, 3'(m_ras.size())}) begin
            errors++;
            $display("FAIL model t=%0t dut pc=%h v=%b rd=%b me=%b cnt=%0d want pc=%h v=%b rd=%b me=%b cnt=%0d",
                     $time, pc_out, pc_valid, redirect_taken, misalign_err, ras_count,
                     m_pc, m_valid, m_redir, m_mis, m_ras.size());
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            checks++;
            if ({pc_out, pc_valid, redirect_taken, misalign_err, ras_count} !==
                {lit_pc, lit_valid, lit_redir, lit_mis, lit_cnt}) begin
                errors++;
                $display("FAIL %s dut pc=%h v=%b rd=%b me=%b cnt=%0d want pc=%h v=%b rd=%b me=%b cnt=%0d",
                         lit_name, pc_out, pc_valid, redirect_taken, misalign_err, ras_count,
                         lit_pc, lit_valid, lit_redir, lit_mis, lit_cnt);
            end
        end
    end

    task automatic expect_out(input string name, input logic [31:0] pc, input logic v,
                              input logic rd, input logic me, input logic [2:0] cnt);
        lit_name = name; lit_pc = pc; lit_valid = v; lit_redir = rd; lit_mis = me; lit_cnt = cnt;
        lit_seq++;
    endtask

    task automatic clear_in();
        stall = 0; flush_valid = 0; flush_target = '0; br_valid = 0; br_sel = 2'd0;
        br_base_pc = '0; rs1_value = '0; imm_offset = '0; ras_push = 0; ras_pop = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic do_br(input logic [1:0] sel, input logic [31:0] base, input logic [31:0] rs1,
                         input logic [31:0] imm);
        br_valid = 1; br_sel = sel; br_base_pc = base; rs1_value = rs1; imm_offset = imm;
    endtask

    initial begin
        rst_n = 0;
        clear_in();
        repeat (2) step();
        expect_out("reset", RV, 0, 0, 0, 0);
        @(negedge clk); #1 rst_n = 1;
        step(); expect_out("boot", 32'h100, 1, 0, 0, 0);
        step(); expect_out("seq1", 32'h104, 1, 0, 0, 0);
        step(); expect_out("seq2", 32'h108, 1, 0, 0, 0);

        flush_valid = 1; flush_target = 32'h200;
        step(); expect_out("flush200", 32'h200, 1, 1, 0, 0);
        stall = 1; do_br(2'd1, 32'h1F8, 32'h0, 32'h10);
        step(); expect_out("br_rel_stall", 32'h208, 1, 1, 0, 0);
        stall = 1; do_br(2'd2, 32'h0, 32'h301, 32'h0);
        step(); expect_out("br_ind_stall", 32'h300, 1, 1, 0, 0);
        stall = 1;
        step(); expect_out("stall_hold", 32'h300, 1, 0, 0, 0);
        step(); expect_out("seq3", 32'h304, 1, 0, 0, 0);

        do_br(2'd2, 32'h0, 32'h302, 32'h0);
        step(); expect_out("misalign", 32'h304, 0, 0, 1, 0);
        do_br(2'd1, 32'h0, 32'h0, 32'h40); ras_push = 1;
        step(); expect_out("err_ignore", 32'h304, 0, 0, 0, 0);
        flush_valid = 1; flush_target = 32'h80;
        step(); expect_out("err_flush", 32'h80, 1, 1, 0, 0);

        for (int a = 1; a <= 5; a++) begin
            do_br(2'd1, 32'(a * 16), 32'h0, 32'h0);
            step();
            ras_push = 1;
            step();
        end
        expect_out("ras_full", 32'h54, 1, 0, 0, 4);
        ras_pop = 1; step(); expect_out("pop1", 32'h54, 1, 1, 0, 3);
        ras_pop = 1; step(); expect_out("pop2", 32'h44, 1, 1, 0, 2);
        ras_pop = 1; step(); expect_out("pop3", 32'h34, 1, 1, 0, 1);
        ras_pop = 1; step(); expect_out("pop4", 32'h24, 1, 1, 0, 0);
        ras_pop = 1; step(); expect_out("pop_empty", 32'h28, 1, 0, 0, 0);

        ras_push = 1; step();
        ras_push = 1; step(); expect_out("push2", 32'h30, 1, 0, 0, 2);
        ras_push = 1; ras_pop = 1;
        step(); expect_out("push_pop", 32'h30, 1, 1, 0, 2);
        ras_pop = 1; step(); expect_out("pop_new_top", 32'h34, 1, 1, 0, 1);
        stall = 1; ras_pop = 1;
        step(); expect_out("stall_pop", 32'h34, 1, 0, 0, 1);

        flush_valid = 1; flush_target = 32'h400; do_br(2'd1, 32'h0, 32'h0, 32'h10); ras_pop = 1;
        step(); expect_out("flush_prio", 32'h400, 1, 1, 0, 0);
        do_br(2'd3, 32'h0, 32'h0, 32'h10);
        step(); expect_out("sel11", 32'h404, 1, 0, 0, 0);
        stall = 1; do_br(2'd0, 32'h0, 32'h0, 32'h10);
        step(); expect_out("sel00_stall", 32'h404, 1, 0, 0, 0);

        flush_valid = 1; flush_target = 32'hFFFF_FFFC;
        step();
        step(); expect_out("wrap", 32'h0, 1, 0, 0, 0);
        do_br(2'd1, 32'h100, 32'h0, 32'h2);
        step(); expect_out("mis_rel", 32'h0, 0, 0, 1, 0);
        flush_valid = 1; flush_target = 32'h500;
        step(); expect_out("recover", 32'h500, 1, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            flush_valid = ($urandom_range(0, 15) == 0);
            flush_target = $urandom & 32'hFFFF_FFFC;
            br_valid    = ($urandom_range(0, 4) == 0);
            br_sel      = 2'($urandom_range(0, 3));
            br_base_pc  = $urandom & 32'hFFFF_FFFC;
            rs1_value   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
            imm_offset  = ($urandom_range(0, 7) == 0) ? 32'h2 : (32'($urandom_range(0, 255)) << 2);
            ras_push    = ($urandom_range(0, 3) == 0);
            ras_pop     = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
        end
        clear_in();
        step();

        #2 rst_n = 0;
        #1 expect_out("async_rst", RV, 0, 0, 0, 0);
        -> probe;
        @(negedge clk); #1 rst_n = 1;
        step(); expect_out("reboot", RV, 1, 0, 0, 0);
        step(); expect_out("reboot_seq", RV + 32'd4, 1, 0, 0, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
